// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the rejection-sampler state encoding.
package dilithium_pkg;

    localparam logic [22:0] Q       = 23'd8380417;
    localparam int unsigned N       = 256;
    localparam int unsigned COEF_W  = 23;
    // Each candidate is drawn from three stream bytes.
    localparam int unsigned GROUP_W = 24;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StParse,
        StDone
    } rej_state_e;

endpackage

// File: rtl/rej_uniform_check.sv
// Turns one 3-byte group into a 23-bit candidate and flags whether it is below q.
module rej_uniform_check
    import dilithium_pkg::*;
(
    input  logic [GROUP_W-1:0] group,
    output logic [COEF_W-1:0]  cand,
    output logic               accept
);

    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;

    // Stream order is b0 first; the top bit of b2 is discarded before the compare.
    always_comb begin
        b0     = group[23:16];
        b1     = group[15:8];
        b2     = group[7:0];
        cand   = COEF_W'({b2 & 8'h7f, b1, b0});
        accept = (cand < Q);
    end

endmodule

// File: rtl/rej_uniform_sampler.sv
// Uniform rejection sampler: requests one SHAKE buffer, then streams the
// coefficients below q over a valid/ready port until N_COEF are delivered.
module rej_uniform_sampler
    import dilithium_pkg::*;
#(
    parameter int unsigned SEED_LEN = 272,
    parameter int unsigned BUF_LEN  = 6720,
    parameter int unsigned N_COEF   = N
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [SEED_LEN-1:0] seed_in,
    output logic                busy,
    output logic                shake_start,
    output logic [SEED_LEN-1:0] shake_seed,
    input  logic                shake_done,
    input  logic [BUF_LEN-1:0]  shake_data,
    output logic                coef_valid,
    input  logic                coef_ready,
    output logic [COEF_W-1:0]   coef_data,
    output logic [7:0]          coef_index,
    output logic                done,
    output logic                error
);

    localparam int unsigned NGroups = BUF_LEN / GROUP_W;
    localparam int unsigned PtrW    = $clog2(NGroups + 1);
    localparam int unsigned CntW    = $clog2(N_COEF + 1);
    localparam logic [PtrW-1:0] PtrEnd = PtrW'(NGroups);
    localparam logic [CntW-1:0] CntEnd = CntW'(N_COEF);

    rej_state_e state_q, state_d;

    logic [SEED_LEN-1:0] seed_q;
    logic [BUF_LEN-1:0]  buf_q;
    logic [PtrW-1:0]     ptr_q;
    logic [CntW-1:0]     cnt_q;
    logic                valid_q;
    logic [COEF_W-1:0]   data_q;
    logic [7:0]          index_q;
    logic                error_q;

    logic [COEF_W-1:0]   cand;
    logic                accept;

    logic start_ok;
    logic latch;
    logic slot_free;
    logic handshake;
    logic all_loaded;
    logic exhausted;
    logic advance;
    logic load;
    logic finish_ok;
    logic finish_err;

    // The current group always sits at the top of the shifting buffer.
    rej_uniform_check u_check (
        .group  (buf_q[BUF_LEN-1 -: GROUP_W]),
        .cand   (cand),
        .accept (accept)
    );

    // Parse control: decide whether the current group is consumed and/or loaded.
    always_comb begin
        start_ok   = (state_q == StIdle) && start && !shake_done;
        latch      = (state_q == StReq) && shake_done;
        slot_free  = !valid_q || coef_ready;
        handshake  = valid_q && coef_ready;
        all_loaded = (cnt_q == CntEnd);
        exhausted  = (ptr_q == PtrEnd);
        advance    = 1'b0;
        load       = 1'b0;
        if ((state_q == StParse) && !all_loaded && !exhausted) begin
            if (!accept) begin
                advance = 1'b1;
            end else if (slot_free) begin
                advance = 1'b1;
                load    = 1'b1;
            end
        end
        finish_ok  = (state_q == StParse) && all_loaded && handshake;
        // Only give up once the last loaded coefficient has left the port.
        finish_err = (state_q == StParse) && !all_loaded && exhausted &&
                     (!valid_q || handshake);
    end

    // State register; reset also drops shake_start immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StReq;
            StReq:   if (shake_done) state_d = StParse;
            StParse: if (finish_ok || finish_err) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy        = (state_q != StIdle);
        shake_start = (state_q == StReq);
        done        = (state_q == StDone);
    end

    // Seed, pointer, count, output slot and error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seed_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (start_ok) begin
                seed_q  <= seed_in;
                ptr_q   <= '0;
                cnt_q   <= '0;
                error_q <= 1'b0;
            end
            if (advance) begin
                ptr_q <= ptr_q + PtrW'(1);
            end
            if (load) begin
                data_q  <= cand;
                index_q <= 8'(cnt_q);
                cnt_q   <= cnt_q + CntW'(1);
                valid_q <= 1'b1;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end
            if (finish_err) begin
                error_q <= 1'b1;
            end
        end
    end

    // Output buffer: loaded once per request, shifted one group per consumed group.
    always_ff @(posedge clock) begin
        if (latch) begin
            buf_q <= shake_data;
        end else if (advance) begin
            buf_q <= {buf_q[BUF_LEN-GROUP_W-1:0], {GROUP_W{1'b0}}};
        end
    end

    assign shake_seed = seed_q;
    assign coef_valid = valid_q;
    assign coef_data  = data_q;
    assign coef_index = index_q;
    assign error      = error_q;

endmodule

// File: tb/tb_rej_uniform_sampler.sv
// Directed bench for rej_uniform_sampler with a 5-cycle SHAKE stub.
module tb_rej_uniform_sampler;

    localparam int unsigned SEED_LEN = 272;
    localparam int unsigned BUF_LEN  = 6720;
    localparam int unsigned N_COEF   = 256;
    localparam int unsigned NGRP     = 280;

    logic                clock;
    logic                reset;
    logic                start;
    logic [SEED_LEN-1:0] seed_in;
    logic                busy;
    logic                shake_start;
    logic [SEED_LEN-1:0] shake_seed;
    logic                shake_done;
    logic [BUF_LEN-1:0]  shake_data;
    logic                coef_valid;
    logic                coef_ready;
    logic [22:0]         coef_data;
    logic [7:0]          coef_index;
    logic                done;
    logic                error;

    logic stub_done;
    logic force_done;
    int   lat_cnt;

    int nchecks;
    int nerr;

    logic [30:0] hs_q[$];
    int done_cnt;
    int req_cnt;
    logic start_prev;

    logic [SEED_LEN-1:0] seed_a;
    logic [SEED_LEN-1:0] seed_b;

    assign shake_done = stub_done | force_done;

    rej_uniform_sampler #(
        .SEED_LEN (SEED_LEN),
        .BUF_LEN  (BUF_LEN),
        .N_COEF   (N_COEF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .seed_in     (seed_in),
        .busy        (busy),
        .shake_start (shake_start),
        .shake_seed  (shake_seed),
        .shake_done  (shake_done),
        .shake_data  (shake_data),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .coef_data   (coef_data),
        .coef_index  (coef_index),
        .done        (done),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // SHAKE stub: done rises a fixed latency after start, falls when start drops.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_cnt   <= 0;
            stub_done <= 1'b0;
        end else if (shake_start && !stub_done) begin
            if (lat_cnt == 4) begin
                stub_done <= 1'b1;
                lat_cnt   <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else if (!shake_start) begin
            stub_done <= 1'b0;
        end
    end

    // Monitor: handshakes, done pulses and SHAKE requests.
    always @(posedge clock) begin
        if (reset) begin
            if (coef_valid && coef_ready) hs_q.push_back({coef_index, coef_data});
            if (done) done_cnt++;
            if (shake_start && !start_prev) req_cnt++;
        end
        start_prev = shake_start;
    end

    task automatic clear_mon();
        hs_q.delete();
        done_cnt = 0;
        req_cnt  = 0;
    endtask

    task automatic fill_groups(input logic [23:0] grp);
        for (int g = 0; g < NGRP; g++) shake_data[BUF_LEN-1-24*g -: 24] = grp;
    endtask

    task automatic set_group(input int g, input logic [23:0] grp);
        shake_data[BUF_LEN-1-24*g -: 24] = grp;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic pulse_start(input logic [SEED_LEN-1:0] s);
        seed_in = s;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is seen, or flags a timeout.
    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        nchecks++;
        if ({busy, shake_start, coef_valid, done, error} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, shake_start, coef_valid, done, error});
        end
        nchecks++;
        if ({coef_data, coef_index} !== 31'd0) begin
            nerr++;
            $display("FAIL reset_coef: got %0h expected 0", {coef_data, coef_index});
        end
        nchecks++;
        if (shake_seed !== '0) begin
            nerr++;
            $display("FAIL reset_seed: got %0h expected 0", shake_seed);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_all_ones();
        bit seen;
        int valid_cycles;
        int bad;
        fill_groups(24'h010000);
        coef_ready = 1'b1;
        clear_mon();
        pulse_start(seed_a);
        nchecks++;
        if (shake_start !== 1'b1) begin
            nerr++;
            $display("FAIL start_to_req: shake_start=%b expected 1", shake_start);
        end
        valid_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (coef_valid) valid_cycles++;
        end
        nchecks++;
        if (!seen) begin
            nerr++;
            $display("FAIL ones_done_timeout: done not seen in 2000 cycles");
        end
        nchecks++;
        if (valid_cycles != 256) begin
            nerr++;
            $display("FAIL ones_throughput: valid cycles %0d expected 256", valid_cycles);
        end
        nchecks++;
        if (hs_q.size() != 256) begin
            nerr++;
            $display("FAIL ones_count: got %0d expected 256", hs_q.size());
        end
        bad = 0;
        for (int i = 0; i < hs_q.size(); i++) begin
            if (hs_q[i] !== {i[7:0], 23'd1}) bad++;
        end
        nchecks++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL ones_values: %0d wrong entries expected 0", bad);
        end
        nchecks++;
        if (error !== 1'b0 || shake_seed !== seed_a) begin
            nerr++;
            $display("FAIL ones_error_seed: error=%b seed_ok=%b expected 0,1",
                     error, shake_seed === seed_a);
        end
        @(negedge clock);
        nchecks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1 || req_cnt != 1) begin
            nerr++;
            $display("FAIL ones_end: done=%b busy=%b pulses=%0d reqs=%0d expected 0 0 1 1",
                     done, busy, done_cnt, req_cnt);
        end
    endtask

    task automatic test_boundaries();
        bit seen;
        fill_groups(24'h010000);
        set_group(0, 24'hffffff);
        set_group(1, 24'h00e07f);
        set_group(2, 24'h01e07f);
        set_group(3, 24'h000080);
        coef_ready = 1'b1;
        clear_mon();
        pulse_start(seed_b);
        wait_done(2000, seen);
        nchecks++;
        if (!seen || hs_q.size() != 256) begin
            nerr++;
            $display("FAIL bound_run: done=%b count=%0d expected 1 256", seen, hs_q.size());
        end
        nchecks++;
        if (hs_q.size() < 3 || hs_q[0] !== {8'd0, 23'd8380416}) begin
            nerr++;
            $display("FAIL bound_qminus1: got %0h expected %0h",
                     (hs_q.size() > 0) ? hs_q[0] : 31'h0, {8'd0, 23'd8380416});
        end
        nchecks++;
        if (hs_q.size() < 3 || hs_q[1] !== {8'd1, 23'd0}) begin
            nerr++;
            $display("FAIL bound_mask: got %0h expected %0h",
                     (hs_q.size() > 1) ? hs_q[1] : 31'h0, {8'd1, 23'd0});
        end
        nchecks++;
        if (hs_q.size() < 3 || hs_q[2] !== {8'd2, 23'd1}) begin
            nerr++;
            $display("FAIL bound_next: got %0h expected %0h",
                     (hs_q.size() > 2) ? hs_q[2] : 31'h0, {8'd2, 23'd1});
        end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        bit seen;
        int bad;
        fill_groups(24'h010000);
        set_group(0, 24'h050000);
        for (int g = 1; g < 6; g++) set_group(g, 24'hffffff);
        set_group(6, 24'h070000);
        coef_ready = 1'b0;
        clear_mon();
        pulse_start(seed_a);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (coef_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        nchecks++;
        if (!seen) begin
            nerr++;
            $display("FAIL bp_first_valid: coef_valid not seen in 100 cycles");
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if ({coef_valid, coef_index, coef_data} !== {1'b1, 8'd0, 23'd5}) bad++;
        end
        nchecks++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL bp_stable: %0d unstable cycles expected 0", bad);
        end
        coef_ready = 1'b1;
        @(negedge clock);
        nchecks++;
        if ({coef_valid, coef_index, coef_data} !== {1'b1, 8'd1, 23'd7}) begin
            nerr++;
            $display("FAIL bp_release: got %0h expected %0h",
                     {coef_valid, coef_index, coef_data}, {1'b1, 8'd1, 23'd7});
        end
        wait_done(2000, seen);
        nchecks++;
        if (!seen || hs_q.size() != 256 || error !== 1'b0) begin
            nerr++;
            $display("FAIL bp_complete: done=%b count=%0d error=%b expected 1 256 0",
                     seen, hs_q.size(), error);
        end
        @(negedge clock);
    endtask

    task automatic test_exhaust();
        bit seen;
        int parse_cycles;
        int valid_cycles;
        fill_groups(24'hffffff);
        coef_ready = 1'b1;
        clear_mon();
        pulse_start(seed_b);
        parse_cycles = 0;
        valid_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy && !shake_start) parse_cycles++;
            if (coef_valid) valid_cycles++;
            @(negedge clock);
        end
        nchecks++;
        if (!seen || error !== 1'b1) begin
            nerr++;
            $display("FAIL exh_error: done=%b error=%b expected 1 1", seen, error);
        end
        nchecks++;
        if (valid_cycles != 0) begin
            nerr++;
            $display("FAIL exh_no_valid: valid cycles %0d expected 0", valid_cycles);
        end
        nchecks++;
        if (parse_cycles < 280 || parse_cycles > 281) begin
            nerr++;
            $display("FAIL exh_parse_len: got %0d expected 280..281", parse_cycles);
        end
        @(negedge clock);
        nchecks++;
        if (busy !== 1'b0 || error !== 1'b1 || done_cnt != 1) begin
            nerr++;
            $display("FAIL exh_after: busy=%b error=%b pulses=%0d expected 0 1 1",
                     busy, error, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        fill_groups(24'h010000);
        coef_ready = 1'b1;
        clear_mon();
        pulse_start(seed_a);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (coef_valid && coef_index == 8'd100) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        nchecks++;
        if (!seen) begin
            nerr++;
            $display("FAIL rmid_reach: index 100 not seen in 500 cycles");
        end
        reset = 1'b0;
        #1;
        nchecks++;
        if ({busy, shake_start, coef_valid, done, error, coef_index, coef_data} !== 36'd0) begin
            nerr++;
            $display("FAIL rmid_clear: got %0h expected 0",
                     {busy, shake_start, coef_valid, done, error, coef_index, coef_data});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        clear_mon();
        pulse_start(seed_b);
        wait_done(2000, seen);
        nchecks++;
        if (!seen || hs_q.size() != 256 || hs_q[0] !== {8'd0, 23'd1}) begin
            nerr++;
            $display("FAIL rmid_restart: done=%b count=%0d first=%0h expected 1 256 1",
                     seen, hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : 31'h0);
        end
        @(negedge clock);
    endtask

    task automatic test_start_ignored();
        bit seen;
        fill_groups(24'h010000);
        coef_ready = 1'b1;
        clear_mon();
        pulse_start(seed_a);
        repeat (20) @(negedge clock);
        pulse_start(seed_b);
        nchecks++;
        if (shake_seed !== seed_a) begin
            nerr++;
            $display("FAIL busy_start_seed: seed changed, expected original seed");
        end
        wait_done(2000, seen);
        nchecks++;
        if (!seen || req_cnt != 1 || hs_q.size() != 256) begin
            nerr++;
            $display("FAIL busy_start_run: done=%b reqs=%0d count=%0d expected 1 1 256",
                     seen, req_cnt, hs_q.size());
        end
        @(negedge clock);
    endtask

    task automatic test_start_while_done_high();
        bit seen;
        int bad;
        fill_groups(24'h010000);
        coef_ready = 1'b1;
        force_done = 1'b1;
        seed_in    = seed_b;
        start      = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (shake_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        nchecks++;
        if (bad != 0) begin
            nerr++;
            $display("FAIL done_high_block: %0d cycles with request expected 0", bad);
        end
        force_done = 1'b0;
        @(negedge clock);
        start = 1'b0;
        nchecks++;
        if (shake_start !== 1'b1) begin
            nerr++;
            $display("FAIL done_high_release: shake_start=%b expected 1", shake_start);
        end
        wait_done(2000, seen);
        nchecks++;
        if (!seen) begin
            nerr++;
            $display("FAIL done_high_finish: done not seen in 2000 cycles");
        end
        @(negedge clock);
    endtask

    initial begin
        nchecks    = 0;
        nerr       = 0;
        start_prev = 1'b0;
        start      = 1'b0;
        coef_ready = 1'b0;
        force_done = 1'b0;
        seed_a     = {17{16'ha5c3}};
        seed_b     = {17{16'h1234}};
        seed_in    = '0;
        shake_data = '0;
        clear_mon();
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        do_reset();
        test_all_ones();
        test_boundaries();
        test_backpressure();
        test_exhaust();
        test_reset_mid();
        test_start_ignored();
        test_start_while_done_high();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/rej_uniform_sampler.md
# rej_uniform_sampler

Dilithium uniform rejection sampler that acts as the initiator of the SHAKE core's start/done handshake. It drives the seed, captures the one-shot SHAKE output buffer, and parses it in 3-byte groups into 23-bit candidates. Candidates below q are streamed out over a valid/ready port until N_COEF coefficients are emitted. It sits between the key/matrix expansion controller and the NTT-domain polynomial RAM.

## Interface
- SEED_LEN, 272: seed width (rho ‖ 16-bit nonce), forwarded to the SHAKE core.
- BUF_LEN, 6720: SHAKE output width in bits; must be a multiple of 24 (default gives 280 groups).
- N_COEF, 256: coefficients per polynomial.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one polynomial; sampled only in IDLE.
- seed_in  in  SEED_LEN  seed; captured on accepted start.
- busy  out  1  high in every state except IDLE.
- shake_start  out  1  SHAKE request, level-held.
- shake_seed  out  SEED_LEN  registered copy of seed_in.
- shake_done  in  1  SHAKE completion level.
- shake_data  in  BUF_LEN  SHAKE output, big-endian: stream byte j = shake_data[BUF_LEN-1-8j -: 8].
- coef_valid  out  1  coefficient available.
- coef_ready  in  1  downstream accepts.
- coef_data  out  23  coefficient, 0..q-1.
- coef_index  out  8  coefficient index 0..N_COEF-1.
- done  out  1  one-cycle completion pulse.
- error  out  1  buffer exhausted before N_COEF accepts; held until next accepted start.

## Operation
- Reset values (reset low): all outputs 0, state IDLE, pointer and count 0.
- IDLE → REQ on start && !shake_done. On this transition: capture seed_in, clear error, pointer and count. start while busy is ignored.
- REQ: shake_start=1. When shake_done=1, latch shake_data into the internal buffer, drop shake_start, go to PARSE.
- PARSE, one group g per cycle:
  - Group bytes are b0=byte 3g, b1=3g+1, b2=3g+2.
  - cand = {b2[6:0], b1, b0}; accept iff cand < Q = 8380417.
  - Output slot free = !coef_valid || coef_ready.
  - Reject: pointer++, regardless of the slot.
  - Accept with slot free: load coef_data=cand, coef_index=count, coef_valid=1; pointer++, count++.
  - Accept with slot blocked: stall; pointer unchanged.
- After the handshake that delivers index N_COEF-1, the next state is DONE.
- If the pointer reaches BUF_LEN/24 with count < N_COEF and the last output has been handshaken, set error=1 and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- coef_valid stays high, with coef_data and coef_index stable, until coef_ready. A handshake with no new load drops coef_valid.
- Reset mid-operation: return to reset values immediately. shake_start drops asynchronously, so the SHAKE core returns to idle.

## Timing
- start accepted at edge t: shake_start high from t+1.
- shake_done sampled high at edge t: buffer latched at t; first candidate evaluated in cycle t+1; earliest coef_valid at t+2.
- Throughput: one group per cycle; one coefficient per cycle with coef_ready held high.
- done asserts the cycle after the final handshake.
- The block never re-asserts shake_start while shake_done is still high from a previous request.

## Structure
- Shared package dilithium_pkg:
  - Q = 23'd8380417, N = 256, COEF_W = 23.
  - State enum: IDLE, REQ, PARSE, DONE.
- One sub-module, rej_uniform_check: combinational byte extraction, 7-bit mask, and `< Q` compare, returning cand and accept.

## Test plan
Use a stub SHAKE model with 5-cycle latency.
- All groups 01 00 00, coef_ready=1 → 256 coefficients of value 1, indices 0..255, done pulse, error=0, shake_start high for exactly one request.
- Groups FF FF FF, 00 E0 7F, 01 E0 7F, 00 00 80 → 8388607 rejected; 8380416 accepted at index 0; 8380417 rejected; 0 accepted at index 1 (bit 23 masked).
- coef_ready low for 10 cycles while valid → coef_data and coef_index stable, count unchanged, trailing reject groups still consumed; on release, the next coefficient follows in 1 cycle.
- All groups FF FF FF → no coef_valid, error=1 and done pulse after 280 parse cycles, busy low afterwards.
- Reset low during PARSE at coefficient 100 → all outputs 0 at once; new start resamples from index 0.
- start pulsed during PARSE → ignored. start while the stub holds shake_done=1 → no shake_start until shake_done falls.
